// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared constants for the TM1638 display path.
// Provides the blank digit code, the digit_shifter mode encoding and the
// driver frame length in clocks.
package tm1638_pkg;
  localparam logic [3:0] BLANK = 4'hF;
  localparam int TM1638_FRAME_CYCLES = 311;
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_ROTL  = 2'b10,
    MODE_ROTR  = 2'b11
  } mode_t;
endpackage

// File: rtl/nibble_fifo.sv
// nibble_fifo: small 4-bit FIFO with synchronous flush.
// Ports: clk, rst_n (async active-low), flush (sync, drops a same-cycle push),
// push/din in, pop/dout out (dout is the head), full, empty.
module nibble_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full   = r_cnt[AW];
  assign empty  = r_cnt == '0;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
endmodule

// File: rtl/digit_shifter.sv
// digit_shifter: feeds hex nibbles across eight TM1638 digits at a fixed step rate.
// Ports: clkinput, rst_n (async active-low); din/din_valid/din_ready push handshake;
// mode (hold/shift-in/rotl/rotr, sampled on each step tick); clear (sync flush+blank);
// seg7..seg0 digit nibbles (seg0 rightmost); led one-hot step marker; step_pulse.
module digit_shifter
  import tm1638_pkg::*;
#(
  parameter int TICK_DIV   = 200000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clkinput,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic [3:0] seg7,
  output logic [3:0] seg6,
  output logic [3:0] seg5,
  output logic [3:0] seg4,
  output logic [3:0] seg3,
  output logic [3:0] seg2,
  output logic [3:0] seg1,
  output logic [3:0] seg0,
  output logic [7:0] led,
  output logic       step_pulse
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0]   r_cnt;
  logic [7:0][3:0] r_seg;
  logic [7:0][3:0] w_seg_nxt;
  logic [7:0]      r_led;
  logic            r_step;
  logic            w_tick, w_step, w_push, w_pop, w_full, w_empty;
  logic [3:0]      w_head, w_new;
  mode_t           w_mode;
  assign w_mode    = mode_t'(mode);
  assign w_tick    = r_cnt == CW'(TICK_DIV - 1);
  assign w_step    = w_tick && w_mode != MODE_HOLD && !clear;
  assign w_pop     = w_step && w_mode == MODE_SHIFT && !w_empty;
  assign din_ready = !w_full;
  assign w_push    = din_valid && din_ready && !clear;
  // An empty FIFO shifts in a blank; a same-cycle push only lands in the FIFO.
  assign w_new     = w_empty ? BLANK : w_head;
  always_comb
    w_seg_nxt = w_mode == MODE_SHIFT ? {r_seg[6:0], w_new} :
                w_mode == MODE_ROTL  ? {r_seg[6:0], r_seg[7]} :
                                       {r_seg[0], r_seg[7:1]};
  always_ff @(posedge clkinput or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_seg  <= {8{BLANK}};
      r_led  <= 8'h01;
      r_step <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_seg  <= {8{BLANK}};
      r_led  <= 8'h01;
      r_step <= 1'b0;
    end else begin
      r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
      r_step <= w_step;
      if (w_step) begin
        r_seg <= w_seg_nxt;
        r_led <= {r_led[6:0], r_led[7]};
      end
    end
  nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clkinput),
    .rst_n (rst_n),
    .flush (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );
  assign {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0} = r_seg;
  assign led        = r_led;
  assign step_pulse = r_step;
endmodule

// File: tb/tb_digit_shifter.sv
// tb_digit_shifter: scoreboard bench for digit_shifter against a queue/array model.
module tb_digit_shifter;
  localparam int TD = 4;
  localparam int FD = 4;
  logic       clkinput = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic [1:0] mode = '0;
  logic       clear = 1'b0;
  logic       din_ready, step_pulse;
  logic [3:0] seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0;
  logic [7:0] led;

  digit_shifter #(.TICK_DIV(TD), .FIFO_DEPTH(FD)) dut (
    .clkinput(clkinput), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .mode(mode), .clear(clear),
    .seg7(seg7), .seg6(seg6), .seg5(seg5), .seg4(seg4),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
    .led(led), .step_pulse(step_pulse)
  );

  always #5 clkinput = ~clkinput;

  longint cyc = 0;
  always @(posedge clkinput) cyc <= cyc + 1;

  wire [31:0] w_segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  typedef struct {
    logic [31:0] segs;
    logic [7:0]  led;
    longint      at;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] mq[$];
  logic [3:0] dig[8];
  int         pcnt, ledpos, nsteps;
  int         total = 0, bad = 0, m_total = 0, m_bad = 0;

  function automatic logic [31:0] mseg();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = dig[i];
    return r;
  endfunction

  function automatic logic [7:0] mled();
    return 8'(1 << ledpos);
  endfunction

  task automatic model_reset();
    pcnt = 0;
    ledpos = 0;
    mq.delete();
    for (int i = 0; i < 8; i++) dig[i] = 4'hF;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] d, input logic [1:0] m, input logic c);
    logic [3:0] old[8];
    logic acc;
    acc = v && mq.size() < FD && !c;
    if (c) begin
      model_reset();
      return;
    end
    if (pcnt == TD - 1 && m != 2'd0) begin
      old = dig;
      for (int i = 0; i < 8; i++)
        case (m)
          2'd1: dig[i] = (i == 0) ? ((mq.size() > 0) ? mq.pop_front() : 4'hF) : old[i-1];
          2'd2: dig[i] = old[(i + 7) % 8];
          default: dig[i] = old[(i + 1) % 8];
        endcase
      ledpos = (ledpos + 1) % 8;
      nsteps++;
      sb.push_back('{mseg(), mled(), cyc + 1});
    end
    if (acc) mq.push_back(d);
    pcnt = (pcnt + 1) % TD;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic chk_state(input string nm);
    chk({nm, " segs"}, w_segs, mseg());
    chk({nm, " led"}, {24'd0, led}, {24'd0, mled()});
  endtask

  task automatic cy(input logic v, input logic [3:0] d, input logic [1:0] m, input logic c);
    din_valid = v;
    din = d;
    mode = m;
    clear = c;
    chk("din_ready", {31'd0, din_ready}, {31'd0, mq.size() < FD});
    model_edge(v, d, m, c);
    @(negedge clkinput);
  endtask

  task automatic run(input int n, input logic [1:0] m);
    repeat (n) cy(1'b0, 4'h0, m, 1'b0);
  endtask

  task automatic run_ticks(input int n, input logic [1:0] m);
    int tgt, b;
    tgt = nsteps + n;
    b = 0;
    while (nsteps < tgt && b < 200) begin
      cy(1'b0, 4'h0, m, 1'b0);
      b++;
    end
  endtask

  task automatic push_val(input logic [3:0] d, input logic [1:0] m);
    logic acc;
    int b;
    acc = 1'b0;
    b = 0;
    while (!acc && b < 50) begin
      acc = din_ready;
      cy(1'b1, d, m, 1'b0);
      b++;
    end
    chk("push accepted", {31'd0, acc}, 32'd1);
  endtask

  always @(negedge clkinput) begin
    if (sb.size() > 0 && sb[0].at < cyc) begin
      m_total++;
      m_bad++;
      e = sb.pop_front();
      $display("FAIL step missed: no step_pulse at cycle %0d", e.at);
    end
    if (step_pulse) begin
      m_total++;
      if (sb.size() == 0) begin
        m_bad++;
        $display("FAIL step unexpected: step_pulse=1 at cycle %0d, want 0", cyc);
      end else begin
        e = sb.pop_front();
        if (w_segs !== e.segs || led !== e.led || cyc != e.at) begin
          m_bad++;
          $display("FAIL step: got segs=%h led=%h cyc=%0d want segs=%h led=%h cyc=%0d",
                   w_segs, led, cyc, e.segs, e.led, e.at);
        end
      end
    end
  end

  initial begin
    int s0;
    model_reset();
    nsteps = 0;
    repeat (3) @(negedge clkinput);
    rst_n = 1'b1;
    chk("reset segs", w_segs, 32'hFFFF_FFFF);
    chk("reset led", {24'd0, led}, 32'h01);
    chk("reset step", {31'd0, step_pulse}, 32'd0);
    chk("reset ready", {31'd0, din_ready}, 32'd1);
    run(20, 2'd0);
    chk("hold segs", w_segs, 32'hFFFF_FFFF);
    chk("hold led", {24'd0, led}, 32'h01);

    push_val(4'h1, 2'd0);
    push_val(4'h2, 2'd0);
    push_val(4'h3, 2'd0);
    run_ticks(3, 2'd1);
    chk("shift3 segs", w_segs, 32'hFFFF_F123);
    chk("shift3 led", {24'd0, led}, 32'h08);
    run_ticks(1, 2'd1);
    chk("shift4 segs", w_segs, 32'hFFFF_123F);
    chk("shift4 led", {24'd0, led}, 32'h10);

    cy(1'b0, 4'h0, 2'd0, 1'b1);
    push_val(4'hA, 2'd0);
    push_val(4'hB, 2'd0);
    push_val(4'hC, 2'd0);
    push_val(4'hD, 2'd0);
    chk("full ready", {31'd0, din_ready}, 32'd0);
    s0 = nsteps;
    push_val(4'h9, 2'd1);
    run_ticks(5 - (nsteps - s0), 2'd1);
    chk("backpressure segs", w_segs, 32'hFFFA_BCD9);
    chk_state("backpressure");

    cy(1'b0, 4'h0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) push_val(4'(i), 2'd0);
    s0 = nsteps;
    for (int i = 4; i < 8; i++) push_val(4'(i), 2'd1);
    run_ticks(8 - (nsteps - s0), 2'd1);
    chk("load segs", w_segs, 32'h0123_4567);
    run_ticks(1, 2'd2);
    chk("rotl segs", w_segs, 32'h1234_5670);
    run_ticks(2, 2'd3);
    chk("rotr segs", w_segs, 32'h7012_3456);
    chk_state("rotate");

    push_val(4'h5, 2'd0);
    push_val(4'h6, 2'd0);
    while (pcnt != TD - 1) cy(1'b0, 4'h0, 2'd1, 1'b0);
    cy(1'b1, 4'h7, 2'd1, 1'b1);
    chk("clear segs", w_segs, 32'hFFFF_FFFF);
    chk("clear led", {24'd0, led}, 32'h01);
    chk("clear ready", {31'd0, din_ready}, 32'd1);
    run_ticks(2, 2'd1);
    chk("after clear segs", w_segs, 32'hFFFF_FFFF);
    chk("after clear led", {24'd0, led}, 32'h04);

    repeat (400)
      cy($urandom_range(0, 2) != 0, 4'($urandom), 2'($urandom), $urandom_range(0, 39) == 0);
    chk_state("random");

    din_valid = 1'b0;
    clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst segs", w_segs, 32'hFFFF_FFFF);
    chk("async rst led", {24'd0, led}, 32'h01);
    chk("async rst step", {31'd0, step_pulse}, 32'd0);
    chk("async rst ready", {31'd0, din_ready}, 32'd1);
    model_reset();
    @(negedge clkinput);
    rst_n = 1'b1;
    repeat (100)
      cy($urandom_range(0, 1) != 0, 4'($urandom), 2'($urandom), 1'b0);
    chk_state("post reset");
    run(4, 2'd0);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total + m_total, bad + m_bad);
    $finish;
  end
endmodule
